// File: rtl/seq_digit_adder.sv
// rtl/seq_digit_adder.sv - multi-cycle adder/subtractor, one DIGIT-bit ripple slice per clock
// Optional zero flag output enabled by defining SEQ_ADDER_ZERO_FLAG_EN.
module seq_digit_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
        $error("seq_digit_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d, ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic              zacc_q, zacc_d, zero_q, zero_d;

    logic [DIGIT-1:0]  a_sl, b_sl, s_sl;
    logic              c_sl, last;

    // Operands shift right each pass, so the active slice is always the low DIGIT bits.
    assign a_sl = a_q[DIGIT-1:0];
    assign b_sl = b_q[DIGIT-1:0];
    assign {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
    assign last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        zacc_d      = zacc_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_RUN;
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = sub ? 1'b1 : cin;
                    cnt_d      = '0;
                    sum_d      = '0;
                    zacc_d     = 1'b0;
                    in_ready_d = 1'b0;
                end
            end
            S_RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) sum_d[k*DIGIT +: DIGIT] = s_sl;
                end
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c_sl;
                cnt_d   = cnt_q + 1'b1;
                zacc_d  = zacc_q | (|s_sl);
                if (last) begin
                    cnt_d       = '0;
                    cout_d      = c_sl;
                    // Carry into the MSB is recovered from the MSB's own sum bit.
                    ovf_d       = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ s_sl[DIGIT-1] ^ c_sl;
                    zero_d      = ~(zacc_q | (|s_sl));
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            zacc_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            zacc_q      <= zacc_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_seq_digit_adder.sv
// tb/tb_seq_digit_adder.sv - randomized self-checking bench for seq_digit_adder
// Instances: 32/8 (N=4), 8/8 (N=1), 16/4 (N=4); zero flag checked when SEQ_ADDER_ZERO_FLAG_EN is defined.
module tb_seq_digit_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  rdy, ovl, co, ov;
    logic [31:0] s32;
    logic [7:0]  s8;
    logic [15:0] s16;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    logic [2:0]  zf;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_digit_adder #(.WIDTH(32), .DIGIT(8)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ovl[0]), .out_ready(out_ready), .sum(s32),
        .cout(co[0]), .ovf(ov[0])
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        , .zero(zf[0])
`endif
    );

    seq_digit_adder #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(ovl[1]), .out_ready(out_ready), .sum(s8),
        .cout(co[1]), .ovf(ov[1])
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        , .zero(zf[1])
`endif
    );

    seq_digit_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .a(a[15:0]), .b(b[15:0]),
        .cin(cin), .sub(sub), .out_valid(ovl[2]), .out_ready(out_ready), .sum(s16),
        .cout(co[2]), .ovf(ov[2])
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        , .zero(zf[2])
`endif
    );

    function automatic int wof(input int s);
        return (s == 0) ? 32 : (s == 1) ? 8 : 16;
    endfunction

    function automatic int nof(input int s);
        return (s == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] get_sum(input int s);
        case (s)
            0:       return s32;
            1:       return {24'b0, s8};
            default: return {16'b0, s16};
        endcase
    endfunction

    // Reference: plain integer arithmetic, returns {cout, ovf, sum}
    function automatic logic [33:0] model(input int s, input logic [31:0] xa, input logic [31:0] xb,
                                          input logic xc, input logic xs);
        int w;
        longint m, half, ua, ub, sa, sb, t, r;
        logic c, o;
        w    = wof(s);
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(xa) & m;
        ub   = longint'(xb) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (xs) begin
            t = ua - ub;
            c = (ua >= ub);
            r = sa - sb;
        end else begin
            t = ua + ub + longint'(xc);
            c = ((t >> w) & 1) != 0;
            r = sa + sb + longint'(xc);
        end
        o = (r >= half) || (r < -half);
        return {c, o, 32'(t & m)};
    endfunction

    task automatic run_op(input int s, input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                          input logic xs, input int hold, input bit pulse);
        logic [33:0] exp;
        int lat;
        int n;
        n   = nof(s);
        exp = model(s, xa, xb, xc, xs);
        a = xa; b = xb; cin = xc; sub = xs; out_ready = 1'b0; iv[s] = 1'b1;
        n_chk++;
        if (rdy[s] !== 1'b1) begin
            n_fail++; $display("FAIL in_ready_idle inst=%0d got=%b want=1", s, rdy[s]);
        end
        @(posedge clk); #1;
        iv[s] = pulse;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (ovl[s] !== 1'b1 && lat < n + 4) begin
            n_chk++;
            if (rdy[s] !== 1'b0) begin
                n_fail++; $display("FAIL in_ready_busy inst=%0d got=%b want=0", s, rdy[s]);
            end
            @(posedge clk); #1;
            iv[s] = 1'b0;
            lat++;
        end
        iv[s] = 1'b0;
        n_chk++;
        if (lat !== n) begin
            n_fail++; $display("FAIL latency inst=%0d got=%0d want=%0d", s, lat, n);
        end
        n_chk++;
        if ({co[s], ov[s], get_sum(s)} !== exp) begin
            n_fail++;
            $display("FAIL result inst=%0d a=%h b=%h cin=%b sub=%b got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h",
                     s, xa, xb, xc, xs, co[s], ov[s], get_sum(s), exp[33], exp[32], exp[31:0]);
        end
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        n_chk++;
        if (zf[s] !== (exp[31:0] == 32'd0)) begin
            n_fail++; $display("FAIL zero inst=%0d got=%b want=%b", s, zf[s], exp[31:0] == 32'd0);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({ovl[s], rdy[s], co[s], ov[s], get_sum(s)} !== {2'b10, exp}) begin
                n_fail++;
                $display("FAIL hold inst=%0d cyc=%0d got v=%b r=%b sum=%h want v=1 r=0 sum=%h",
                         s, i, ovl[s], rdy[s], get_sum(s), exp[31:0]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_chk++;
        if ({ovl[s], rdy[s]} !== 2'b01) begin
            n_fail++; $display("FAIL drain inst=%0d got v=%b r=%b want v=0 r=1", s, ovl[s], rdy[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_chk++;
            if ({rdy[s], ovl[s], co[s], ov[s], get_sum(s)} !== {4'b1000, 32'd0}) begin
                n_fail++;
                $display("FAIL reset inst=%0d got r=%b v=%b c=%b o=%b sum=%h want r=1 v=0 c=0 o=0 sum=0",
                         s, rdy[s], ovl[s], co[s], ov[s], get_sum(s));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b0);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
        run_op(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 10, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++;
        if ({rdy[0], ovl[0], s32} !== {2'b10, 32'd0}) begin
            n_fail++; $display("FAIL reset_mid_op got r=%b v=%b sum=%h want r=1 v=0 sum=0", rdy[0], ovl[0], s32);
        end
        repeat (6) begin
            @(posedge clk); #1;
            n_chk++;
            if (ovl[0] !== 1'b0) begin
                n_fail++; $display("FAIL no_partial got v=%b want 0", ovl[0]);
            end
        end
        run_op(0, 32'd1, 32'd2, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_single_pass();
        run_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0);
        run_op(1, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 6; i++) run_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
        for (int i = 0; i < 10; i++)
            run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_single_pass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
